scarv_soc_bram_arbiter: RTL and testbench
=========================================

// Module: scarv_soc_bram_arbiter
//
// PURPOSE
//  Shares port A of a 32-bit dual-port byte-write BRAM between two requesters:
//  r0 (instruction fetch) and r1 (data/DMA). It uses round-robin arbitration
//  and valid/ready request and response channels, with one outstanding
//  transaction per requester. A per-requester hold register keeps each
//  response stable until that requester accepts it. Sits between the CPU
//  memory interfaces and the BRAM; port B is untouched.
//
// PARAMETERS
//  DEPTH  1024           BRAM depth in bytes; must match the attached BRAM.
//  LW     $clog2(DEPTH)  localparam: byte-address width.
//
// PORTS
//  clka           in   1    clock, shared with the BRAM port A
//  rsta           in   1    synchronous active-high reset
//  reqN_valid     in   1    requester N (N=0,1) presents a request
//  reqN_ready     out  1    request accepted this cycle when valid&ready
//  reqN_addr      in   LW   byte address; bits [1:0] ignored
//  reqN_wstrb     in   4    byte write enables; 0 = read
//  reqN_wdata     in   32   write data
//  rspN_valid     out  1    response available
//  rspN_ready     in   1    requester consumes the response
//  rspN_rdata     out  32   read data; for writes, the new word (write-first)
//  bram_ena       out  1    BRAM port A enable
//  bram_wea       out  4    BRAM port A byte write enables
//  bram_addra     out  LW   BRAM port A address
//  bram_dina      out  32   BRAM port A write data
//  bram_douta     in   32   BRAM port A registered read data (1-cycle)
//
// BEHAVIOUR
//  - Reset (rsta=1 at a clka edge):
//    - pendN=0, heldN=0, last=1 (r0 wins the first contention).
//    - All outputs are 0 during reset; any in-flight response is dropped.
//  - Eligibility: eligN = ~pendN | (rspN_valid & rspN_ready). The
//    rsp->req_ready path is combinational.
//  - Grant: exactly one requester is granted per cycle.
//    - gN = reqN_valid & eligN & ~(other requester wins).
//    - On contention, the winner is the requester != last.
//    - reqN_ready = gN; never depends on reqN_valid of the other requester
//      beyond arbitration.
//  - BRAM drive (combinational from the grant):
//    - bram_ena=g0|g1.
//    - addr, wstrb and wdata are muxed from the granted requester.
//    - When idle, all BRAM outputs are 0.
//  - On grant at edge T: last<=N, pendN<=1, liveN<=1 (response comes from
//    bram_douta in T+1).
//  - Cycle T+1: rspN_valid=1, rspN_rdata=bram_douta (1-cycle latency).
//    - If rspN_ready=1: pendN clears unless re-granted the same cycle.
//    - Else: holdN<=bram_douta, heldN<=1, liveN<=0.
//  - Held state: rspN_valid=1 and rspN_rdata=holdN until ready. The held
//    value is immune to later BRAM traffic from the other requester.
//  - Back-to-back: the same requester may issue every cycle if it accepts
//    each response in the same cycle (100% throughput for a single
//    requester).
//  - Under contention the two requesters alternate; each sees 50% throughput.
//  - Write response: rdata = the merged word after the write, since the BRAM
//    is write-first.
//  - Reset mid-operation: pend, held and live clear and the response is lost;
//    the requester must reissue.
//
// TESTING
//  1. Read: r1 writes 0xDEADBEEF @0x10 (wstrb=F); r0 reads 0x10.
//     -> r0 sees rsp0_valid exactly 1 cycle after accept, rdata=0xDEADBEEF.
//  2. Contention: both valid continuously after reset.
//     -> grants go r0,r1,r0,r1...; bram_addra alternates accordingly.
//  3. Backpressure: r0 reads 0x20 (=0x11223344) with rsp0_ready=0 for 5
//     cycles while r1 writes 0x20 := 0x0.
//     -> rsp0_rdata stays 0x11223344; req0_ready=0 throughout.
//  4. Byte write: mem[0x30]=0xAABBCCDD; r1 writes wstrb=0x2, wdata=0x00005500.
//     -> rsp1_rdata=0xAABB55DD; a later read returns the same.
//  5. Streaming: r0 reads 0x0..0x3C consecutively with rsp0_ready=1, r1 idle.
//     -> 16 responses in 17 cycles, in order.
//  6. Reset: rsta asserted in the cycle after grant.
//     -> rsp0_valid=0 after reset; the next contention grants r0 first.

Source files
------------

// File: rtl/scarv_soc_bram_arbiter.sv
// scarv_soc_bram_arbiter
//   Round-robin arbiter that shares BRAM port A between two requesters:
//   r0 (instruction fetch) and r1 (data/DMA). Each requester has its own
//   valid/ready request and response channels and may have one transaction
//   outstanding. The BRAM returns read data one cycle after the access.
//   If a requester is not ready when that data arrives, the data is captured
//   in a per-requester hold register. The response then stays stable while
//   the other requester keeps using the BRAM.
module scarv_soc_bram_arbiter #(
   parameter  int unsigned DEPTH = 1024,
   localparam int unsigned LW    = $clog2(DEPTH)
) (
   input  logic          clka,
   input  logic          rsta,

   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [LW-1:0] req0_addr,
   input  logic [3:0]    req0_wstrb,
   input  logic [31:0]   req0_wdata,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [31:0]   rsp0_rdata,

   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [LW-1:0] req1_addr,
   input  logic [3:0]    req1_wstrb,
   input  logic [31:0]   req1_wdata,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [31:0]   rsp1_rdata,

   output logic          bram_ena,
   output logic [3:0]    bram_wea,
   output logic [LW-1:0] bram_addra,
   output logic [31:0]   bram_dina,
   input  logic [31:0]   bram_douta
);

   // Per-requester views of the ports, indexed by requester number.
   logic [1:0]           req_valid;
   logic [1:0][LW-1:0]   req_addr;
   logic [1:0][3:0]      req_wstrb;
   logic [1:0][31:0]     req_wdata;
   logic [1:0]           rsp_ready;
   logic [1:0]           rsp_valid;
   logic [1:0][31:0]     rsp_rdata;

   logic [1:0]           elig;
   logic [1:0]           want;
   logic [1:0]           grant;

   // Registered state.
   //   pend : transaction outstanding.
   //   live : response is on bram_douta this cycle.
   //   held : response is parked in the hold register.
   //   last : the requester granted most recently (1 means r1).
   logic [1:0]           pend_q, pend_d;
   logic [1:0]           live_q, live_d;
   logic [1:0]           held_q, held_d;
   logic [1:0][31:0]     hold_q, hold_d;
   logic                 last_q, last_d;

   // Gather the port signals into indexed vectors.
   always_comb begin
      req_valid = {req1_valid, req0_valid};
      req_addr  = {req1_addr,  req0_addr};
      req_wstrb = {req1_wstrb, req0_wstrb};
      req_wdata = {req1_wdata, req0_wdata};
      rsp_ready = {rsp1_ready, rsp0_ready};
   end

   // Response channels. The hold register takes priority over the live
   // BRAM data. All responses are forced to 0 while reset is asserted.
   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         if (!rsta) begin
            rsp_valid[i] = live_q[i] | held_q[i];
            if (held_q[i]) begin
               rsp_rdata[i] = hold_q[i];
            end else if (live_q[i]) begin
               rsp_rdata[i] = bram_douta;
            end
         end
      end
   end

   // Eligibility and round-robin grant. A requester whose response is
   // consumed this cycle may issue again at once, so rsp_ready feeds
   // req_ready combinationally. On contention the requester that was not
   // granted last wins.
   always_comb begin
      elig  = '0;
      want  = '0;
      grant = '0;
      for (int unsigned i = 0; i < 2; i++) begin
         elig[i] = ~pend_q[i] | (rsp_valid[i] & rsp_ready[i]);
         want[i] = ~rsta & req_valid[i] & elig[i];
      end
      grant[0] = want[0] & (~want[1] |  last_q);
      grant[1] = want[1] & (~want[0] | ~last_q);
   end

   // Drive BRAM port A from the granted requester. All outputs are 0 when idle.
   always_comb begin
      bram_ena   = |grant;
      bram_wea   = '0;
      bram_addra = '0;
      bram_dina  = '0;
      if (grant[1]) begin
         bram_wea   = req_wstrb[1];
         bram_addra = req_addr[1];
         bram_dina  = req_wdata[1];
      end else if (grant[0]) begin
         bram_wea   = req_wstrb[0];
         bram_addra = req_addr[0];
         bram_dina  = req_wdata[0];
      end
   end

   // Scatter the indexed vectors back onto the ports.
   always_comb begin
      req0_ready = grant[0];
      req1_ready = grant[1];
      rsp0_valid = rsp_valid[0];
      rsp1_valid = rsp_valid[1];
      rsp0_rdata = rsp_rdata[0];
      rsp1_rdata = rsp_rdata[1];
   end

   // Next-state logic for the per-requester transaction tracking.
   always_comb begin
      last_d = last_q;
      pend_d = pend_q;
      live_d = grant;
      held_d = held_q;
      hold_d = hold_q;
      if (grant[0]) last_d = 1'b0;
      if (grant[1]) last_d = 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
         // Capture live data the requester did not take this cycle.
         if (live_q[i] && !rsp_ready[i]) begin
            held_d[i] = 1'b1;
            hold_d[i] = bram_douta;
         end
         if (held_q[i] && rsp_ready[i]) begin
            held_d[i] = 1'b0;
         end
         // A re-grant in the same cycle keeps the transaction pending.
         if (rsp_valid[i] && rsp_ready[i]) begin
            pend_d[i] = 1'b0;
         end
         if (grant[i]) begin
            pend_d[i] = 1'b1;
         end
      end
   end

   // State registers with synchronous reset. Reset makes r0 win first.
   always_ff @(posedge clka) begin
      if (rsta) begin
         pend_q <= '0;
         live_q <= '0;
         held_q <= '0;
         hold_q <= '0;
         last_q <= 1'b1;
      end else begin
         pend_q <= pend_d;
         live_q <= live_d;
         held_q <= held_d;
         hold_q <= hold_d;
         last_q <= last_d;
      end
   end

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
// tb_scarv_soc_bram_arbiter
//   Directed bench for the BRAM arbiter. A behavioural write-first BRAM with
//   a 1-cycle registered read is attached to port A. Each table row holds
//   one cycle of stimulus and the expected outputs for that cycle, which are
//   computed by hand. A separate sequence then checks single-requester
//   streaming.
module tb_scarv_soc_bram_arbiter;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned LW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
   logic [LW-1:0] req0_addr;
   logic [3:0]    req0_wstrb;
   logic [31:0]   req0_wdata, rsp0_rdata;
   logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
   logic [LW-1:0] req1_addr;
   logic [3:0]    req1_wstrb;
   logic [31:0]   req1_wdata, rsp1_rdata;
   logic          bram_ena;
   logic [3:0]    bram_wea;
   logic [LW-1:0] bram_addra;
   logic [31:0]   bram_dina;
   logic [31:0]   bram_douta = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   scarv_soc_bram_arbiter #(.DEPTH(DEPTH)) dut (
      .clka(clk), .rsta(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
      .req0_wstrb(req0_wstrb), .req0_wdata(req0_wdata),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
      .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata),
      .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
      .bram_dina(bram_dina), .bram_douta(bram_douta)
   );

   // Behavioural BRAM port A. Word i is preloaded with 0xA5000000 | i on the
   // first clock edge.
   logic [31:0] mem [DEPTH/4];
   logic        init_done = 1'b0;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] din,
                                         input logic [3:0]  we);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = din[8*b +: 8];
      return w;
   endfunction

   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < DEPTH/4; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         init_done <= 1'b1;
      end else if (bram_ena) begin
         mem[bram_addra[LW-1:2]] <= merge(mem[bram_addra[LW-1:2]], bram_dina, bram_wea);
         bram_douta              <= merge(mem[bram_addra[LW-1:2]], bram_dina, bram_wea);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        v0;  logic [9:0] a0; logic [3:0] ws0; logic [31:0] wd0; logic rr0;
      logic        v1;  logic [9:0] a1; logic [3:0] ws1; logic [31:0] wd1; logic rr1;
      logic        e_rdy0, e_rdy1;
      logic        e_rv0;  logic [31:0] e_rd0;
      logic        e_rv1;  logic [31:0] e_rd1;
      logic        e_ena;  logic [9:0] e_addr; logic [3:0] e_wea;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   // Expected content of word i after the table has run.
   function automatic logic [31:0] exp_word(input int i);
      case (i)
         4:       return 32'hDEAD_BEEF;
         8:       return 32'h0000_0000;
         12:      return 32'hAABB_55DD;
         default: return 32'hA500_0000 | 32'(i);
      endcase
   endfunction

   initial begin
      int issued, got, grants_seen;
      //          rst v0 a0  ws0 wd0            rr0 v1 a1  ws1 wd1            rr1  rdy0 rdy1 rv0 rd0            rv1 rd1            ena addr wea
      // Row 0: held in reset with r0 requesting; every output must be 0.
      vecs[0]  = '{1, 1,'h10,0,0,             0, 0,'h00,0,0,             0,   0,0, 0,0,             0,0,             0,'h00,0};
      // Rows 1-3: r1 writes 0xDEADBEEF to 0x10, then r0 reads it back.
      vecs[1]  = '{0, 0,'h00,0,0,             0, 1,'h10,4'hF,32'hDEADBEEF,1, 0,1, 0,0,             0,0,             1,'h10,4'hF};
      vecs[2]  = '{0, 1,'h10,0,0,             1, 0,'h00,0,0,             1,   1,0, 0,0,             1,32'hDEADBEEF,  1,'h10,0};
      vecs[3]  = '{0, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 1,32'hDEADBEEF,  0,0,             0,'h00,0};
      // Rows 4-7: byte-lane write. The response is the merged word.
      vecs[4]  = '{0, 0,'h00,0,0,             1, 1,'h30,4'hF,32'hAABBCCDD,1, 0,1, 0,0,             0,0,             1,'h30,4'hF};
      vecs[5]  = '{0, 0,'h00,0,0,             1, 1,'h30,4'h2,32'h00005500,1, 0,1, 0,0,             1,32'hAABBCCDD,  1,'h30,4'h2};
      vecs[6]  = '{0, 1,'h30,0,0,             1, 0,'h00,0,0,             1,   1,0, 0,0,             1,32'hAABB55DD,  1,'h30,0};
      vecs[7]  = '{0, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 1,32'hAABB55DD,  0,0,             0,'h00,0};
      // Rows 8-16: r0's response is back-pressured while r1 overwrites the same word.
      vecs[8]  = '{0, 0,'h00,0,0,             1, 1,'h20,4'hF,32'h11223344,1, 0,1, 0,0,             0,0,             1,'h20,4'hF};
      vecs[9]  = '{0, 1,'h20,0,0,             0, 0,'h00,0,0,             1,   1,0, 0,0,             1,32'h11223344,  1,'h20,0};
      vecs[10] = '{0, 1,'h20,0,0,             0, 1,'h20,4'hF,0,          1,   0,1, 1,32'h11223344,  0,0,             1,'h20,4'hF};
      vecs[11] = '{0, 1,'h20,0,0,             0, 0,'h00,0,0,             1,   0,0, 1,32'h11223344,  1,0,             0,'h00,0};
      vecs[12] = '{0, 1,'h20,0,0,             0, 0,'h00,0,0,             1,   0,0, 1,32'h11223344,  0,0,             0,'h00,0};
      vecs[13] = '{0, 1,'h20,0,0,             0, 0,'h00,0,0,             1,   0,0, 1,32'h11223344,  0,0,             0,'h00,0};
      vecs[14] = '{0, 1,'h20,0,0,             0, 0,'h00,0,0,             1,   0,0, 1,32'h11223344,  0,0,             0,'h00,0};
      vecs[15] = '{0, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 1,32'h11223344,  0,0,             0,'h00,0};
      vecs[16] = '{0, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 0,0,             0,0,             0,'h00,0};
      // Rows 17-20: reset, then both requesters stay valid. Grants alternate r0,r1,r0.
      vecs[17] = '{1, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 0,0,             0,0,             0,'h00,0};
      vecs[18] = '{0, 1,'h00,0,0,             1, 1,'h04,0,0,             1,   1,0, 0,0,             0,0,             1,'h00,0};
      vecs[19] = '{0, 1,'h00,0,0,             1, 1,'h04,0,0,             1,   0,1, 1,32'hA5000000,  0,0,             1,'h04,0};
      vecs[20] = '{0, 1,'h00,0,0,             1, 1,'h04,0,0,             1,   1,0, 0,0,             1,32'hA5000001,  1,'h00,0};
      // Rows 21-23: reset in the cycle after r0 is granted. The response is
      // dropped, and r0 still wins the next contention.
      vecs[21] = '{1, 1,'h00,0,0,             1, 1,'h04,0,0,             1,   0,0, 0,0,             0,0,             0,'h00,0};
      vecs[22] = '{0, 1,'h00,0,0,             1, 1,'h04,0,0,             1,   1,0, 0,0,             0,0,             1,'h00,0};
      vecs[23] = '{0, 0,'h00,0,0,             1, 0,'h00,0,0,             1,   0,0, 1,32'hA5000000,  0,0,             0,'h00,0};

      rst = 1'b1;
      req0_valid = 0; req0_addr = '0; req0_wstrb = '0; req0_wdata = '0; rsp0_ready = 0;
      req1_valid = 0; req1_addr = '0; req1_wstrb = '0; req1_wdata = '0; rsp1_ready = 0;

      for (int r = 0; r < NV; r++) begin
         @(negedge clk);
         rst        = vecs[r].rst;
         req0_valid = vecs[r].v0; req0_addr = vecs[r].a0; req0_wstrb = vecs[r].ws0;
         req0_wdata = vecs[r].wd0; rsp0_ready = vecs[r].rr0;
         req1_valid = vecs[r].v1; req1_addr = vecs[r].a1; req1_wstrb = vecs[r].ws1;
         req1_wdata = vecs[r].wd1; rsp1_ready = vecs[r].rr1;
         #1;
         chk($sformatf("row%0d.req0_ready", r), 32'(req0_ready), 32'(vecs[r].e_rdy0));
         chk($sformatf("row%0d.req1_ready", r), 32'(req1_ready), 32'(vecs[r].e_rdy1));
         chk($sformatf("row%0d.rsp0_valid", r), 32'(rsp0_valid), 32'(vecs[r].e_rv0));
         chk($sformatf("row%0d.rsp1_valid", r), 32'(rsp1_valid), 32'(vecs[r].e_rv1));
         if (vecs[r].e_rv0) chk($sformatf("row%0d.rsp0_rdata", r), rsp0_rdata, vecs[r].e_rd0);
         if (vecs[r].e_rv1) chk($sformatf("row%0d.rsp1_rdata", r), rsp1_rdata, vecs[r].e_rd1);
         chk($sformatf("row%0d.bram_ena", r),   32'(bram_ena),   32'(vecs[r].e_ena));
         chk($sformatf("row%0d.bram_addra", r), 32'(bram_addra), 32'(vecs[r].e_addr));
         chk($sformatf("row%0d.bram_wea", r),   32'(bram_wea),   32'(vecs[r].e_wea));
      end

      // Streaming: r0 reads words 0..15 back-to-back while r1 is idle.
      // Sixteen responses are expected in order within 17 cycles.
      issued = 0; got = 0; grants_seen = 0;
      for (int c = 0; c < 17; c++) begin
         @(negedge clk);
         rst        = 1'b0;
         req1_valid = 1'b0;
         rsp0_ready = 1'b1;
         req0_valid = (issued < 16);
         req0_wstrb = '0;
         req0_addr  = LW'(issued * 4);
         #1;
         if (rsp0_valid) begin
            chk($sformatf("stream.rdata%0d", got), rsp0_rdata, exp_word(got));
            got++;
         end
         if (req0_ready) begin
            grants_seen++;
            issued++;
         end
      end
      @(negedge clk);
      req0_valid = 1'b0;
      chk("stream.grants", 32'(grants_seen), 32'd16);
      chk("stream.responses", 32'(got), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
